// File: rtl/opl3_reg_sequencer.sv
// Host-side OPL3 register-write sequencer: command FIFO feeding an index/data strobe FSM with us delays and IRQ waits.
// Optional macro OPL_INIT_CLEAR_EN: after reset, writes 0x00 to all 512 register indices before accepting commands.
module opl3_reg_sequencer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int WE_CYCLES      = 2,
    parameter int IDX_DELAY_US   = 4,
    parameter int DAT_DELAY_US   = 23,
    parameter int IRQ_TIMEOUT_US = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1us,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [18:0] cmd,
    output logic [1:0]  opl_addr,
    output logic [7:0]  opl_dout,
    output logic        opl_we,
    input  logic        opl_irq_n,
    output logic        busy,
    output logic        err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] C_WE  = 16'(WE_CYCLES - 1);
    localparam logic [15:0] C_IDX = 16'(IDX_DELAY_US);
    localparam logic [15:0] C_DAT = 16'(DAT_DELAY_US);
    localparam logic [15:0] C_TMO = 16'(IRQ_TIMEOUT_US);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_IDX_STB, S_IDX_WAIT, S_DAT_STB, S_DAT_WAIT, S_DELAY, S_WAIT_IRQ
`ifdef OPL_INIT_CLEAR_EN
        , S_INIT
`endif
    } state_t;

    state_t      r_state;
    logic [18:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [1:0]  r_op;
    logic        r_bank;
    logic [7:0]  r_reg, r_dat;
    logic [15:0] r_cnt;
    logic [1:0]  r_addr;
    logic [7:0]  r_dout;
    logic        r_we, r_err;
    logic        w_empty, w_full, w_push, w_wait_done, w_init_block;

`ifdef OPL_INIT_CLEAR_EN
    logic        r_init_run;
    logic [8:0]  r_init_idx;
    assign w_init_block = r_init_run;
`else
    assign w_init_block = 1'b0;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = cmd_valid && cmd_ready;
    // A zero count finishes in one clk; otherwise the final ce_1us pulse ends the wait.
    assign w_wait_done = (r_cnt == 16'd0) || (ce_1us && (r_cnt == 16'd1));

    assign cmd_ready   = !w_full && !w_init_block;
    assign busy        = !w_empty || (r_state != S_IDLE) || w_init_block;
    assign opl_addr    = r_addr;
    assign opl_dout    = r_dout;
    assign opl_we      = r_we;
    assign err_timeout = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_wr_ptr <= '0;
        else if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef OPL_INIT_CLEAR_EN
            r_state    <= S_INIT;
            r_init_run <= 1'b1;
            r_init_idx <= '0;
`else
            r_state    <= S_IDLE;
`endif
            r_rd_ptr <= '0;
            r_op     <= '0;
            r_bank   <= 1'b0;
            r_reg    <= '0;
            r_dat    <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_dout   <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    {r_op, r_bank, r_reg, r_dat} <= r_mem[r_rd_ptr[AW-1:0]];
                    r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                    r_state  <= S_LOAD;
                end
                S_LOAD: case (r_op)
                    2'd0: begin
                        r_addr  <= {r_bank, 1'b0};
                        r_dout  <= r_reg;
                        r_we    <= 1'b1;
                        r_cnt   <= C_WE;
                        r_state <= S_IDX_STB;
                    end
                    2'd1: begin
                        r_cnt   <= {r_reg, r_dat};
                        r_state <= S_DELAY;
                    end
                    2'd2: begin
                        r_cnt   <= C_TMO;
                        r_state <= S_WAIT_IRQ;
                    end
                    default: r_state <= S_IDLE;
                endcase
                S_IDX_STB: if (r_cnt == 16'd0) begin
                    r_we    <= 1'b0;
                    r_cnt   <= C_IDX;
                    r_state <= S_IDX_WAIT;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                S_IDX_WAIT: if (w_wait_done) begin
                    r_addr  <= {r_bank, 1'b1};
                    r_dout  <= r_dat;
                    r_we    <= 1'b1;
                    r_cnt   <= C_WE;
                    r_state <= S_DAT_STB;
                end else if (ce_1us) begin
                    r_cnt <= r_cnt - 16'd1;
                end
                S_DAT_STB: if (r_cnt == 16'd0) begin
                    r_we    <= 1'b0;
                    r_cnt   <= C_DAT;
                    r_state <= S_DAT_WAIT;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
                S_DAT_WAIT: if (w_wait_done) begin
`ifdef OPL_INIT_CLEAR_EN
                    if (r_init_run && (r_init_idx != 9'h1FF)) begin
                        r_init_idx <= r_init_idx + 9'd1;
                        r_state    <= S_INIT;
                    end else begin
                        r_init_run <= 1'b0;
                        r_state    <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end else if (ce_1us) begin
                    r_cnt <= r_cnt - 16'd1;
                end
                S_DELAY: if (w_wait_done) r_state <= S_IDLE;
                         else if (ce_1us) r_cnt <= r_cnt - 16'd1;
                // IRQ wins over a timeout expiring in the same clk; the flag reset is reg 0x04 <- 0x80.
                S_WAIT_IRQ: if (!opl_irq_n) begin
                    r_bank  <= 1'b0;
                    r_reg   <= 8'h04;
                    r_dat   <= 8'h80;
                    r_addr  <= 2'b00;
                    r_dout  <= 8'h04;
                    r_we    <= 1'b1;
                    r_cnt   <= C_WE;
                    r_state <= S_IDX_STB;
                end else if (w_wait_done) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end else if (ce_1us) begin
                    r_cnt <= r_cnt - 16'd1;
                end
`ifdef OPL_INIT_CLEAR_EN
                S_INIT: begin
                    r_bank  <= r_init_idx[8];
                    r_reg   <= r_init_idx[7:0];
                    r_dat   <= 8'h00;
                    r_addr  <= {r_init_idx[8], 1'b0};
                    r_dout  <= r_init_idx[7:0];
                    r_we    <= 1'b1;
                    r_cnt   <= C_WE;
                    r_state <= S_IDX_STB;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opl3_reg_sequencer.sv
// Directed bench for opl3_reg_sequencer (default build); ce_1us pulses every 5 clks, strobes logged by a monitor.
module tb_opl3_reg_sequencer;
    localparam int TMO = 120;
    localparam int HN  = 16384;
    localparam int EN  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_1us = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [18:0] cmd = '0;
    logic [1:0]  opl_addr;
    logic [7:0]  opl_dout;
    logic        opl_we;
    logic        opl_irq_n = 1'b1;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    opl3_reg_sequencer #(
        .FIFO_DEPTH(16), .WE_CYCLES(2), .IDX_DELAY_US(4), .DAT_DELAY_US(23), .IRQ_TIMEOUT_US(TMO)
    ) dut (
        .clk(clk), .reset(reset), .ce_1us(ce_1us), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .opl_addr(opl_addr), .opl_dout(opl_dout), .opl_we(opl_we), .opl_irq_n(opl_irq_n),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            ce_1us = (div == 0);
            div = (div == 4) ? 0 : div + 1;
        end
    end

    // Per-edge history: cyc = index of the last rising edge, ce_at = pulses sampled up to it.
    int cyc = 0;
    int ce_cnt = 0;
    int ce_at [HN];
    bit ce_hit [HN];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ce_1us) ce_cnt = ce_cnt + 1;
        if (cyc < HN) begin
            ce_at[cyc]  = ce_cnt;
            ce_hit[cyc] = ce_1us;
        end
    end

    logic [1:0] ev_addr [EN];
    logic [7:0] ev_dout [EN];
    int ev_rise [EN];
    int ev_fall [EN];
    int ev_hi [EN];
    int ev_n = 0;
    int unstable = 0;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (ev_n < EN) begin
            if (opl_we && !prev_we) begin
                ev_addr[ev_n] = opl_addr;
                ev_dout[ev_n] = opl_dout;
                ev_rise[ev_n] = cyc;
                ev_hi[ev_n]   = 1;
            end else if (opl_we) begin
                ev_hi[ev_n] = ev_hi[ev_n] + 1;
                if (opl_addr !== ev_addr[ev_n] || opl_dout !== ev_dout[ev_n]) unstable = unstable + 1;
            end else if (prev_we) begin
                ev_fall[ev_n] = cyc;
                ev_n = ev_n + 1;
            end
        end
        prev_we = opl_we;
    end

    function automatic logic [18:0] mk(input logic [1:0] op, input logic bank, input logic [7:0] rg, input logic [7:0] d);
        return {op, bank, rg, d};
    endfunction

    task automatic push(input logic [18:0] c, output int pcyc, output logic rdy);
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        rdy = cmd_ready;
        @(posedge clk);
        #1;
        pcyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int bcyc);
        int n;
        n = 0;
        bcyc = -1;
        while (n < 6000 && bcyc < 0) begin
            @(negedge clk);
            if (!busy) bcyc = cyc;
            n++;
        end
        checks++;
        if (bcyc < 0) begin
            errors++;
            $display("FAIL %s_idle: busy still 1 after 6000 clks, required 0", nm);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 6;
        if (opl_we !== 1'b0)      begin errors++; $display("FAIL rst_we: got %b want 0", opl_we); end
        if (opl_addr !== 2'd0)    begin errors++; $display("FAIL rst_addr: got %0d want 0", opl_addr); end
        if (opl_dout !== 8'h00)   begin errors++; $display("FAIL rst_dout: got %h want 00", opl_dout); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks += 2;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        int p, b, e;
        logic r;
        e = ev_n;
        push(mk(2'd0, 1'b1, 8'h05, 8'h01), p, r);
        wait_idle("write", b);
        checks++;
        if (ev_n - e !== 2) begin errors++; $display("FAIL wr_count: got %0d strobes want 2", ev_n - e); end
        checks += 9;
        if (ev_addr[e] !== 2'd2 || ev_dout[e] !== 8'h05)
            begin errors++; $display("FAIL wr_idx: got addr %0d dout %h want 2 05", ev_addr[e], ev_dout[e]); end
        if (ev_addr[e+1] !== 2'd3 || ev_dout[e+1] !== 8'h01)
            begin errors++; $display("FAIL wr_dat: got addr %0d dout %h want 3 01", ev_addr[e+1], ev_dout[e+1]); end
        if (ev_rise[e] !== p + 2) begin errors++; $display("FAIL wr_latency: rise at %0d want %0d", ev_rise[e], p + 2); end
        if (ev_hi[e] !== 2)   begin errors++; $display("FAIL wr_idx_width: got %0d clks want 2", ev_hi[e]); end
        if (ev_hi[e+1] !== 2) begin errors++; $display("FAIL wr_dat_width: got %0d clks want 2", ev_hi[e+1]); end
        if (ce_at[ev_rise[e+1]] - ce_at[ev_fall[e]] !== 4)
            begin errors++; $display("FAIL wr_idx_delay: got %0d us want 4", ce_at[ev_rise[e+1]] - ce_at[ev_fall[e]]); end
        if (ce_hit[ev_rise[e+1]] !== 1'b1) begin errors++; $display("FAIL wr_idx_edge: got %b want 1", ce_hit[ev_rise[e+1]]); end
        if (ce_at[b] - ce_at[ev_fall[e+1]] !== 23)
            begin errors++; $display("FAIL wr_dat_delay: got %0d us want 23", ce_at[b] - ce_at[ev_fall[e+1]]); end
        if (ce_hit[b] !== 1'b1) begin errors++; $display("FAIL wr_busy_edge: got %b want 1", ce_hit[b]); end
    endtask

    task automatic test_delay();
        int p, q, b, e;
        logic r;
        e = ev_n;
        push(mk(2'd1, 1'b0, 8'h00, 8'h03), p, r);
        push(mk(2'd0, 1'b0, 8'h20, 8'h11), q, r);
        wait_idle("delay3", b);
        checks += 3;
        if (ev_addr[e] !== 2'd0 || ev_dout[e] !== 8'h20)
            begin errors++; $display("FAIL dly3_idx: got addr %0d dout %h want 0 20", ev_addr[e], ev_dout[e]); end
        if (ce_at[ev_rise[e] - 2] - ce_at[p + 2] !== 3)
            begin errors++; $display("FAIL dly3_us: got %0d us want 3", ce_at[ev_rise[e] - 2] - ce_at[p + 2]); end
        if (ce_hit[ev_rise[e] - 2] !== 1'b1) begin errors++; $display("FAIL dly3_edge: got %b want 1", ce_hit[ev_rise[e] - 2]); end
        e = ev_n;
        push(mk(2'd1, 1'b0, 8'h00, 8'h00), p, r);
        push(mk(2'd0, 1'b1, 8'h21, 8'h12), q, r);
        wait_idle("delay0", b);
        checks += 2;
        if (ev_rise[e] !== p + 5) begin errors++; $display("FAIL dly0_rise: at %0d want %0d", ev_rise[e], p + 5); end
        if (ev_addr[e+1] !== 2'd3 || ev_dout[e+1] !== 8'h12)
            begin errors++; $display("FAIL dly0_dat: got addr %0d dout %h want 3 12", ev_addr[e+1], ev_dout[e+1]); end
    endtask

    task automatic test_wait_irq();
        int p, b, e, c0, n, k;
        logic r;
        e = ev_n;
        push(mk(2'd2, 1'b0, 8'h00, 8'h00), p, r);
        c0 = ce_cnt;
        n = 0;
        while (ce_cnt < c0 + 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        opl_irq_n = 1'b0;
        k = cyc;
        wait_idle("irq", b);
        opl_irq_n = 1'b1;
        checks += 5;
        if (ev_n - e !== 2) begin errors++; $display("FAIL irq_count: got %0d strobes want 2", ev_n - e); end
        if (ev_rise[e] !== k + 1) begin errors++; $display("FAIL irq_latency: rise at %0d want %0d", ev_rise[e], k + 1); end
        if (ev_addr[e] !== 2'd0 || ev_dout[e] !== 8'h04)
            begin errors++; $display("FAIL irq_idx: got addr %0d dout %h want 0 04", ev_addr[e], ev_dout[e]); end
        if (ev_addr[e+1] !== 2'd1 || ev_dout[e+1] !== 8'h80)
            begin errors++; $display("FAIL irq_dat: got addr %0d dout %h want 1 80", ev_addr[e+1], ev_dout[e+1]); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL irq_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_back_to_back();
        int p, q, b, e;
        logic r;
        logic bk;
        push(mk(2'd1, 1'b0, 8'h00, 8'd20), p, r);
        e = ev_n;
        for (int i = 0; i < 17; i++) begin
            bk = i[0];
            push(mk(2'd0, bk, 8'(8'h30 + i), 8'(8'hA0 + i)), q, r);
            checks++;
            if (r !== (i < 16))
                begin errors++; $display("FAIL b2b_ready_%0d: got %b want %b", i, r, (i < 16)); end
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: cmd_ready %b want 0", cmd_ready); end
        wait_idle("b2b", b);
        checks++;
        if (ev_n - e !== 32) begin errors++; $display("FAIL b2b_count: got %0d strobes want 32", ev_n - e); end
        for (int i = 0; i < 16; i++) begin
            bk = i[0];
            checks++;
            if (ev_addr[e+2*i] !== {bk, 1'b0} || ev_dout[e+2*i] !== 8'(8'h30 + i) ||
                ev_addr[e+2*i+1] !== {bk, 1'b1} || ev_dout[e+2*i+1] !== 8'(8'hA0 + i) ||
                ev_hi[e+2*i] !== 2 || ev_hi[e+2*i+1] !== 2)
                begin errors++; $display("FAIL b2b_cmd_%0d: got %0d/%h %0d/%h want %0d/%h %0d/%h", i,
                    ev_addr[e+2*i], ev_dout[e+2*i], ev_addr[e+2*i+1], ev_dout[e+2*i+1],
                    {bk, 1'b0}, 8'(8'h30 + i), {bk, 1'b1}, 8'(8'hA0 + i)); end
        end
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL b2b_stable: %0d changes during strobes want 0", unstable); end
    endtask

    task automatic test_timeout();
        int p, q, b, e, n, t;
        logic r;
        e = ev_n;
        push(mk(2'd2, 1'b0, 8'h00, 8'h00), p, r);
        push(mk(2'd0, 1'b0, 8'h40, 8'h3F), q, r);
        n = 0;
        t = -1;
        while (t < 0 && n < 2000) begin
            @(negedge clk);
            if (err_timeout) t = cyc;
            n++;
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL tmo_set: err_timeout 0 after 2000 clks want 1");
            t = p + 3;
        end
        wait_idle("tmo", b);
        checks += 5;
        if (ce_at[t] - ce_at[p + 2] !== TMO)
            begin errors++; $display("FAIL tmo_us: got %0d us want %0d", ce_at[t] - ce_at[p + 2], TMO); end
        if (ce_hit[t] !== 1'b1) begin errors++; $display("FAIL tmo_edge: got %b want 1", ce_hit[t]); end
        if (ev_rise[e] !== t + 2) begin errors++; $display("FAIL tmo_next: rise at %0d want %0d", ev_rise[e], t + 2); end
        if (ev_addr[e] !== 2'd0 || ev_dout[e] !== 8'h40 || ev_addr[e+1] !== 2'd1 || ev_dout[e+1] !== 8'h3F)
            begin errors++; $display("FAIL tmo_write: got %0d/%h %0d/%h want 0/40 1/3f",
                ev_addr[e], ev_dout[e], ev_addr[e+1], ev_dout[e+1]); end
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid_strobe();
        int p, n, e;
        logic r;
        push(mk(2'd0, 1'b1, 8'h55, 8'hAA), p, r);
        n = 0;
        while (opl_we !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (opl_we !== 1'b1) begin errors++; $display("FAIL mid_we_high: got %b want 1", opl_we); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks += 4;
        if (opl_we !== 1'b0)      begin errors++; $display("FAIL mid_we_drop: got %b want 0", opl_we); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL mid_err_clear: got %b want 0", err_timeout); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        e = ev_n;
        repeat (30) @(negedge clk);
        checks += 2;
        if (ev_n !== e) begin errors++; $display("FAIL mid_lost: got %0d new strobes want 0", ev_n - e); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_delay();
        test_wait_irq();
        test_back_to_back();
        test_timeout();
        test_reset_mid_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
